spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 cmd_start  input  1  one-cycle request; accepted only when busy=0.
REQ-005 cmd_code  input  8  opcode byte; sent first.
REQ-006 cmd_data  input  32  argument; sent only when cmd_long=1, byte [7:0] first.
REQ-007 cmd_long  input  1  1 = 5-byte command, 0 = 1-byte command.
REQ-008 rd_bytes  input  3  number of response bytes to clock in after the command, 0..4.
REQ-009 busy  output  1  transaction in progress.
REQ-010 rsp_data  output  32  response bytes; first received byte in [7:0].
REQ-011 rsp_valid  output  1  one-cycle pulse when rsp_data is updated.
REQ-012 spi_cs_n  output  1  active-low chip select.
REQ-013 spi_sclk  output  1  serial clock, mode 0.
REQ-014 spi_mosi  output  1  master-out data.
REQ-015 spi_miso  input  1  master-in data; synchronised by two flops before use.

Function
REQ-016 On cmd_start with busy=0, the block shall latch cmd_code, cmd_data, cmd_long and rd_bytes, and assert busy on the next cycle.
REQ-017 cmd_start while busy=1 shall be ignored, without being queued.
REQ-018 States: IDLE -> SETUP -> SHIFT -> HOLD -> GUARD -> IDLE.
REQ-019 SETUP: drive spi_cs_n=0 and the first MOSI bit; hold for CLK_DIV cycles before the first SCLK rise.
REQ-020 SHIFT: each bit is SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles; MSB first within each byte.
REQ-021 MOSI shall change only on the SCLK falling edge (or on SETUP entry); MISO shall be sampled on the SCLK rising edge, with the 2-cycle synchroniser delay compensated.
REQ-022 Byte count: 1 + 4*cmd_long + rd_bytes, transferred back-to-back with no inter-byte gap.
REQ-023 MOSI shall be 0 during response bytes.
REQ-024 HOLD: SCLK low, spi_cs_n still 0, for CLK_DIV cycles; then spi_cs_n=1.
REQ-025 GUARD: spi_cs_n=1 for 2*CLK_DIV cycles; busy remains 1.
REQ-026 busy shall fall on GUARD exit, and rsp_valid shall pulse in that same cycle.
REQ-027 rsp_data bytes beyond rd_bytes shall be 0, and rsp_data shall hold its value until the next rsp_valid.
REQ-028 rd_bytes values 5..7 shall be treated as 4.
REQ-029 With rd_bytes=0, rsp_valid shall still pulse and rsp_data shall be 0.
REQ-030 SCLK period shall be exactly 2*CLK_DIV clk cycles, so a byte takes 16*CLK_DIV cycles.

Reset
REQ-031 rst asserted at any time, including mid-transaction, shall immediately force IDLE and the following outputs: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, rsp_valid=0, rsp_data=0.
REQ-032 After rst deasserts, the first cmd_start shall be accepted normally.
REQ-033 A partial transfer aborted by reset shall produce no rsp_valid pulse.

Configuration
REQ-034 Macro SPI_MASTER_LOOPBACK_EN, when defined, shall make the block sample its own spi_mosi in place of spi_miso, with identical synchroniser latency.
REQ-035 With SPI_MASTER_LOOPBACK_EN undefined, spi_miso shall be used and there shall be no loopback logic.

Verification
REQ-036 Short command: CLK_DIV=4, cmd_code=0x02, cmd_long=0, rd_bytes=4, slave model returns 0x31,0x41,0x4C,0x53 -> MOSI carries 0x02 then zeros; rsp_data=0x534C4131 with one rsp_valid pulse; cs_n low 5*64+8 cycles.
REQ-037 Long command: cmd_code=0xC0, cmd_data=0x12345678, cmd_long=1, rd_bytes=0 -> MOSI bytes 0xC0,0x78,0x56,0x34,0x12; rsp_valid pulses; rsp_data=0.
REQ-038 Busy drop: cmd_start pulsed mid-transfer -> no second transaction; exactly one cs_n low window.
REQ-039 Reset mid-operation: rst asserted during byte 2 -> cs_n=1 and sclk=0 immediately; no rsp_valid; next command completes correctly.
REQ-040 Timing: CLK_DIV=2, rd_bytes=7 -> treated as 4; SCLK high/low exactly 2 cycles each; 40 SCLK rises total.
REQ-041 Loopback build: SPI_MASTER_LOOPBACK_EN defined, cmd_code=0xA5, cmd_long=1, cmd_data=0, rd_bytes=1 -> rsp_data=0x00000000; patched to echo during command bytes, sampled bits match MOSI.

Source files
------------

// File: rtl/spi_master.sv
// SPI mode-0 command master: opcode byte, optional 32-bit argument, then up to four response bytes.
// Build option SPI_MASTER_LOOPBACK_EN feeds the block's own spi_mosi into the receive path in place of spi_miso.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic [7:0]  cmd_code,
    input  logic [31:0] cmd_data,
    input  logic        cmd_long,
    input  logic [2:0]  rd_bytes,
    output logic        busy,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int unsigned CW = 9;
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(2 * CLK_DIV - 1);
    // Two synchroniser stages: the level present at an SCLK rise reaches miso_s2 two clocks later.
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GUARD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hi;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic [3:0]    byte_last;
    logic [2:0]    cmd_bytes;
    logic [39:0]   tx_sr;
    logic [7:0]    rx_byte;
    logic [31:0]   rx_acc;
    logic          miso_s1;
    logic          miso_s2;
    logic          miso_src;
    logic [2:0]    rd_eff;
    logic [3:0]    byte_last_c;
    logic [1:0]    rsp_sel;
    logic [7:0]    rx_next;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_src = spi_mosi;
`else
    assign miso_src = spi_miso;
`endif

    assign rd_eff      = (rd_bytes > 3'd4) ? 3'd4 : rd_bytes;
    assign byte_last_c = (cmd_long ? 4'd5 : 4'd1) + 4'(rd_eff) - 4'd1;
    assign rsp_sel     = 2'(byte_idx - 4'(cmd_bytes));
    assign rx_next     = {rx_byte[6:0], miso_s2};

    // Each bit is SCLK high for CLK_DIV then low for CLK_DIV; SETUP supplies the low half before the first rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= 1'b0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            byte_last <= '0;
            cmd_bytes <= '0;
            tx_sr     <= '0;
            rx_byte   <= '0;
            rx_acc    <= '0;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            miso_s1   <= miso_src;
            miso_s2   <= miso_s1;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        state     <= SETUP;
                        busy      <= 1'b1;
                        spi_cs_n  <= 1'b0;
                        spi_mosi  <= cmd_code[7];
                        cnt       <= '0;
                        hi        <= 1'b0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                        rx_acc    <= '0;
                        byte_last <= byte_last_c;
                        cmd_bytes <= cmd_long ? 3'd5 : 3'd1;
                        tx_sr     <= cmd_long ? {cmd_code, cmd_data[7:0], cmd_data[15:8],
                                                 cmd_data[23:16], cmd_data[31:24]}
                                              : {cmd_code, 32'h0};
                    end
                end
                SETUP: begin
                    if (cnt == HALF_LAST) begin
                        state    <= SHIFT;
                        spi_sclk <= 1'b1;
                        hi       <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT: begin
                    if (hi && cnt == SAMPLE_AT) begin
                        rx_byte <= rx_next;
                        if (bit_idx == 3'd7 && byte_idx >= 4'(cmd_bytes))
                            rx_acc[{rsp_sel, 3'b000} +: 8] <= rx_next;
                    end
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (hi) begin
                            // Falling edge: present the next bit; zeros shift in behind the command.
                            spi_sclk <= 1'b0;
                            hi       <= 1'b0;
                            spi_mosi <= tx_sr[38];
                            tx_sr    <= {tx_sr[38:0], 1'b0};
                        end else if (bit_idx == 3'd7 && byte_idx == byte_last) begin
                            state <= HOLD;
                        end else begin
                            spi_sclk <= 1'b1;
                            hi       <= 1'b1;
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                byte_idx <= byte_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    spi_mosi <= 1'b0;
                    if (cnt == HALF_LAST) begin
                        state    <= GUARD;
                        spi_cs_n <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GUARD: begin
                    if (cnt == GUARD_LAST) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_acc;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
